monitor_q: RTL
==============

# monitor_q

Downstream observer for the `flipflopjk` output: samples `q` on every enabled clock and registers one-cycle `rise` and `fall` pulses. It keeps a saturating edge counter and flags each serial occurrence of a programmable bit pattern, with overlapping matches allowed. It sits directly after the JK flip-flop stage and uses the same `clk` and `enable`, so lab benches can check `q` behaviour (toggle, hold, set, reset) in hardware instead of by reading `$monitor` output.

## Interface
Parameters:
- `PAT_LEN`, 4: pattern length in bits, 2..8.
- `PATTERN`, 4'b1011: pattern to detect. MSB is the oldest sample.
- `CNT_W`, 8: width of `edge_count` and `match_count`.

Ports:
- `clk`  in  1  single clock; all logic updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  sample qualifier; when low, `q` is ignored and all state holds.
- `clear`  in  1  synchronous clear of counters and sample history.
- `q`  in  1  output of the JK flip-flop under observation.
- `rise`  out  1  one-cycle pulse: enabled sample went 0→1.
- `fall`  out  1  one-cycle pulse: enabled sample went 1→0.
- `detect`  out  1  one-cycle pulse: last `PAT_LEN` enabled samples equal `PATTERN`.
- `edge_count`  out  CNT_W  rises plus falls since reset/clear; saturates.
- `match_count`  out  CNT_W  number of `detect` pulses since reset/clear; saturates.

## Operation
- Priority on every clock edge: `reset` > `clear` > enabled sample > hold.
- Reset values:
  - all outputs 0;
  - `prev` = 0, `prev_valid` = 0;
  - `hist` = 0, `fill` = 0.
- `clear`:
  - same effect as reset on counters, history, `prev_valid` and `fill`;
  - the sample presented in the same cycle is discarded;
  - pulses are 0 in the following cycle.
- Enabled sample (`enable`=1, no reset or clear):
  - `rise` <= `prev_valid & q & ~prev`;
  - `fall` <= `prev_valid & ~q & prev`;
  - then `prev` <= `q` and `prev_valid` <= 1.
- The first sample after reset or clear never produces an edge.
- History:
  - `hist` <= {`hist[PAT_LEN-2:0]`, `q`};
  - `fill` <= min(`fill`+1, `PAT_LEN`).
- Detection: `detect` <= (`fill` ≥ `PAT_LEN`-1) & ({`hist[PAT_LEN-2:0]`, `q`} == `PATTERN`).
  - `hist` is never reset on a match, so overlapping matches count.
- `edge_count` increments by 1 on each cycle that sets `rise` or `fall`.
- `match_count` increments by 1 on each `detect`.
- Both counters hold at 2^CNT_W−1 once reached; they never wrap.
- `enable`=0: pulses drop to 0 at the next edge; `prev`, `hist`, `fill` and the counters hold.
- Fill-level FSM, states FILL_0 … FILL_N (N = `PAT_LEN`):
  - advances one state per enabled sample;
  - stays in FILL_N;
  - returns to FILL_0 on reset or clear.

## Timing
- Latency: a sample taken at edge k produces `rise`/`fall`/`detect` visible after edge k, lasting exactly one cycle. The counters show the new value in that same cycle.
- With `enable` held high, back-to-back pulses are allowed on consecutive cycles. Example: a JK toggle (`j`=`k`=1) gives alternating `rise` and `fall` every cycle.
- `rise` and `fall` are never high in the same cycle.
- `detect` can coincide with `rise` or `fall`.
- `reset` or `clear` asserted mid-stream: pulses are 0 in the next cycle, and the next enabled sample is treated as a first sample.
- No combinational path from any input to any output.

## Structure
- Package `monitor_q_pkg`: default `PAT_LEN`, `PATTERN`, `CNT_W`, and the saturating-increment function.
- Sub-module `edge_detect`: holds `prev`/`prev_valid`, takes `clk`, `reset`, `clear`, `enable`, `q`, and produces `rise`/`fall`. Instantiated once.
- Top level contains the history shift register, the fill FSM and both counters.

## Test plan
- Reset held for 2 cycles, then released with `q`=1 on the first sample → no `rise`; all outputs 0; `edge_count`=0.
- `enable`=1 and `q` sequence 0,1,1,0 → `rise` after the 2nd sample, `fall` after the 4th; `edge_count`=2.
- `q` sequence 1,0,1,1,0,1,1 → `detect` after the 4th and 7th samples (overlap); `match_count`=2.
- `enable`=0 for 3 cycles while `q` toggles, then `enable`=1 with `q` unchanged from the last enabled sample → no pulses; counters unchanged.
- `clear` asserted between samples 1,0,1 and a following 1 → no `detect`; `match_count`=0; `fill` restarts from 0.
- With `CNT_W`=3, 10 toggles (`q` alternating every cycle) → `edge_count` saturates and stays at 7.

Source files
------------

// File: rtl/monitor_q_pkg.sv
// Shared defaults, fill-level state encoding and the saturating-increment
// helper for the monitor_q observer.
package monitor_q_pkg;

    localparam int                     DEF_PAT_LEN = 4;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1011;
    localparam int                     DEF_CNT_W   = 8;
    localparam int                     MAX_PAT_LEN = 8;

    // Fill level of the sample history. One state per sample collected,
    // sized for the largest supported pattern length.
    typedef enum logic [3:0] {
        FILL_0,
        FILL_1,
        FILL_2,
        FILL_3,
        FILL_4,
        FILL_5,
        FILL_6,
        FILL_7,
        FILL_8
    } fill_e;

    // Counter increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/monitor_q_edge_detect.sv
// Edge detector for the observed q: remembers the previous enabled sample
// and emits one-cycle rise/fall pulses. edge_hit is the combinational
// "this edge will pulse" term so the top can bump its counter in step.
module edge_detect
    import monitor_q_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic q,
    output logic rise,
    output logic fall,
    output logic edge_hit
);

    logic r_prev;
    logic r_prev_valid;
    logic r_rise;
    logic r_fall;
    logic w_rise;
    logic w_fall;

    // An edge needs a valid previous sample; the first sample never pulses.
    assign w_rise   = r_prev_valid & q & ~r_prev;
    assign w_fall   = r_prev_valid & ~q & r_prev;
    assign edge_hit = enable & (w_rise | w_fall);

    assign rise = r_rise;
    assign fall = r_fall;

    // Previous-sample register and registered pulses; reset > clear > sample > hold.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset || clear) begin
            r_prev       <= 1'b0;
            r_prev_valid <= 1'b0;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
        end else if (enable) begin
            r_rise       <= w_rise;
            r_fall       <= w_fall;
            r_prev       <= q;
            r_prev_valid <= 1'b1;
        end else begin
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
        end
    end

endmodule

// File: rtl/monitor_q.sv
// monitor_q: observer for a JK flip-flop output. Produces rise/fall/detect
// pulses one cycle after each enabled sample, plus saturating counters of
// edges and pattern matches (overlapping matches allowed).
module monitor_q
    import monitor_q_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int                 CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             q,
    output logic             rise,
    output logic             fall,
    output logic             detect,
    output logic [CNT_W-1:0] edge_count,
    output logic [CNT_W-1:0] match_count
);

    localparam fill_e            FILL_FULL = fill_e'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [PAT_LEN-1:0] r_hist;
    fill_e              r_fill;
    fill_e              w_fill_next;
    logic               r_detect;
    logic [CNT_W-1:0]   r_edge_count;
    logic [CNT_W-1:0]   r_match_count;

    logic [PAT_LEN-1:0] w_hist_next;
    logic               w_match;
    logic               w_edge_hit;
    logic [CNT_W-1:0]   w_edge_inc;
    logic [CNT_W-1:0]   w_match_inc;

    edge_detect u_edge_detect (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .enable   (enable),
        .q        (q),
        .rise     (rise),
        .fall     (fall),
        .edge_hit (w_edge_hit)
    );

    // The history never clears on a match, so overlapping patterns are seen.
    assign w_hist_next = {r_hist[PAT_LEN-2:0], q};
    assign w_match     = enable
                       & (int'(r_fill) >= PAT_LEN - 1)
                       & (w_hist_next == PATTERN);

    assign w_edge_inc  = CNT_W'(sat_inc(32'(r_edge_count),  32'(CNT_MAX)));
    assign w_match_inc = CNT_W'(sat_inc(32'(r_match_count), 32'(CNT_MAX)));

    assign detect      = r_detect;
    assign edge_count  = r_edge_count;
    assign match_count = r_match_count;

    // Fill-level state register; reset and clear both restart at FILL_0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_fill <= FILL_0;
        end else begin
            r_fill <= w_fill_next;
        end
    end

    // Fill-level next state: one step per enabled sample, parked at FILL_N.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_fill_next = r_fill;
        if (enable && (r_fill != FILL_FULL)) begin
            w_fill_next = fill_e'(r_fill + 4'd1);
        end
    end

    // Sample history, detect pulse and both saturating counters.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_hist        <= '0;
            r_detect      <= 1'b0;
            r_edge_count  <= '0;
            r_match_count <= '0;
        end else if (enable) begin
            r_hist   <= w_hist_next;
            r_detect <= w_match;
            if (w_edge_hit) begin
                r_edge_count <= w_edge_inc;
            end
            if (w_match) begin
                r_match_count <= w_match_inc;
            end
        end else begin
            r_detect <= 1'b0;
        end
    end

endmodule
